pwm_capture: RTL and testbench

- Receive-side counterpart to the servo PWM generators: measures the high time and period of an incoming servo-style PWM signal, counted in clk_in cycles.
- Sits on an external feedback or RC-receiver pin.
- Presents one registered measurement per completed frame, with a single-cycle valid strobe and a loss-of-signal flag.
- Nominal frame is 50 Hz at 98.304 MHz, which is 1_966_080 cycles.

---
 rtl/pwm_capture.sv | 102 ++++++++++
 tb/tb_pwm_capture.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// Servo-style PWM receiver: measures high time and rise-to-rise period of pwm_in
// in clk_in cycles, with a one-cycle valid strobe and a sticky loss-of-signal flag.
module pwm_capture #(
    parameter int WIDTH          = 22,
    parameter int TIMEOUT_CYCLES = 3_932_160,
    parameter int SYNC_STAGES    = 2
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             pwm_in,
    output logic [WIDTH-1:0] high_out,
    output logic [WIDTH-1:0] period_out,
    output logic             valid_out,
    output logic             timeout_out
);

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } state_t;

    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(TIMEOUT_CYCLES);
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic                   prev;
    logic                   rise;
    logic                   fall;
    state_t                 state;
    logic [WIDTH-1:0]       cnt;
    logic [WIDTH-1:0]       cnt_inc;
    logic [WIDTH-1:0]       high_lat;

    // NOTE: prev resets to 0 so a pin already high at reset release is seen as a rise.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pwm_in};
            prev <= s;
        end
    end

    assign s       = sync[SYNC_STAGES-1];
    assign rise    = s & ~prev;
    assign fall    = ~s & prev;
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

    // NOTE: all state and outputs use non-blocking assignments so every branch reads
    // the pre-edge values of cnt and high_lat.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state       <= IDLE;
            cnt         <= '0;
            high_lat    <= '0;
            high_out    <= '0;
            period_out  <= '0;
            valid_out   <= 1'b0;
            timeout_out <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (rise) begin
                        cnt   <= CNT_ONE;
                        state <= HIGH;
                    end
                end
                default: begin
                    // An edge always takes priority over the timeout check.
                    if (rise) begin
                        cnt   <= CNT_ONE;
                        state <= HIGH;
                        if (state == LOW) begin
                            period_out  <= cnt;
                            high_out    <= high_lat;
                            valid_out   <= 1'b1;
                            timeout_out <= 1'b0;
                        end
                    end else if (fall) begin
                        cnt <= cnt_inc;
                        if (state == HIGH) begin
                            high_lat <= cnt;
                            state    <= LOW;
                        end
                    end else if (cnt == CNT_MAX) begin
                        cnt         <= '0;
                        state       <= IDLE;
                        timeout_out <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture using scaled-down counter parameters so that
// timeouts and full frames fit in a short run.
module tb_pwm_capture;

    localparam int W   = 12;
    localparam int T   = 200;
    localparam int SS  = 2;
    localparam int LAT = SS + 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         pwm = 1'b0;
    logic [W-1:0] high_out;
    logic [W-1:0] period_out;
    logic         valid_out;
    logic         timeout_out;

    pwm_capture #(
        .WIDTH(W),
        .TIMEOUT_CYCLES(T),
        .SYNC_STAGES(SS)
    ) dut (
        .clk_in(clk),
        .rst_in(rst),
        .pwm_in(pwm),
        .high_out(high_out),
        .period_out(period_out),
        .valid_out(valid_out),
        .timeout_out(timeout_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned h;
        int unsigned p;
        int unsigned c;
    } meas_t;

    typedef struct {
        int unsigned high_in;
        int unsigned period_in;
        int unsigned exp_high;
        int unsigned exp_period;
        int unsigned exp_gap;
    } vec_t;

    meas_t       q[$];
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic        prev_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (valid_out) begin
            check("valid_single_cycle", 32'(prev_valid), 32'd0);
            q.push_back('{h: 32'(high_out), p: 32'(period_out), c: cyc});
        end
        prev_valid = valid_out;
    endtask

    task automatic run_frame(input int unsigned h, input int unsigned p, output int unsigned rc);
        pwm = 1'b1;
        rc  = cyc;
        repeat (h) tick();
        pwm = 1'b0;
        repeat (p - h) tick();
    endtask

    task automatic wait_until(input int unsigned target);
        while (cyc < target) tick();
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    vec_t        vecs[6];
    int unsigned rc;
    int          n;

    initial begin
        vecs[0] = '{high_in: 15,  period_in: 100, exp_high: 15,  exp_period: 100, exp_gap: 100};
        vecs[1] = '{high_in: 1,   period_in: 10,  exp_high: 1,   exp_period: 10,  exp_gap: 10};
        vecs[2] = '{high_in: 9,   period_in: 10,  exp_high: 9,   exp_period: 10,  exp_gap: 10};
        vecs[3] = '{high_in: 1,   period_in: 2,   exp_high: 1,   exp_period: 2,   exp_gap: 2};
        vecs[4] = '{high_in: 30,  period_in: 200, exp_high: 30,  exp_period: 200, exp_gap: 200};
        vecs[5] = '{high_in: 199, period_in: 200, exp_high: 199, exp_period: 200, exp_gap: 200};

        // Reset state, then a long idle input: nothing may be reported.
        repeat (3) tick();
        check("rst_high", 32'(high_out), 32'd0);
        check("rst_period", 32'(period_out), 32'd0);
        check("rst_valid", 32'(valid_out), 32'd0);
        check("rst_timeout", 32'(timeout_out), 32'd0);
        rst = 1'b0;
        repeat (3 * T) tick();
        check("idle_valid_count", 32'(q.size()), 32'd0);
        check("idle_timeout", 32'(timeout_out), 32'd0);
        check("idle_high", 32'(high_out), 32'd0);
        check("idle_period", 32'(period_out), 32'd0);

        // Table: four frames of each shape; the last three valids describe that shape.
        foreach (vecs[i]) begin
            q.delete();
            repeat (4) run_frame(vecs[i].high_in, vecs[i].period_in, rc);
            repeat (LAT) tick();
            n = q.size();
            check("tbl_valid_count_ge3", 32'(n >= 3), 32'd1);
            if (n >= 3) begin
                check("tbl_high_last", q[n-1].h, vecs[i].exp_high);
                check("tbl_period_last", q[n-1].p, vecs[i].exp_period);
                check("tbl_high_prev", q[n-2].h, vecs[i].exp_high);
                check("tbl_period_prev", q[n-2].p, vecs[i].exp_period);
                check("tbl_gap", q[n-1].c - q[n-2].c, vecs[i].exp_gap);
            end
        end

        // Three good frames, then the pin stays low until the timeout fires.
        repeat (3) run_frame(15, 100, rc);
        wait_until(rc + T + 2);
        check("lo_timeout_before", 32'(timeout_out), 32'd0);
        q.delete();
        tick();
        check("lo_timeout_at", 32'(timeout_out), 32'd1);
        repeat (50) tick();
        check("lo_timeout_sticky", 32'(timeout_out), 32'd1);
        check("lo_hold_high", 32'(high_out), 32'd15);
        check("lo_hold_period", 32'(period_out), 32'd100);
        check("lo_no_valid", 32'(q.size()), 32'd0);

        // Restart: first rise silent, second rise reports and clears the timeout.
        run_frame(15, 100, rc);
        check("restart_first_rise_silent", 32'(q.size()), 32'd0);
        pwm = 1'b1;
        rc  = cyc;
        repeat (LAT - 1) tick();
        check("restart_valid_early", 32'(valid_out), 32'd0);
        check("restart_timeout_early", 32'(timeout_out), 32'd1);
        tick();
        check("restart_valid_latency", 32'(valid_out), 32'd1);
        check("restart_timeout_clear", 32'(timeout_out), 32'd0);
        check("restart_high", 32'(high_out), 32'd15);
        check("restart_period", 32'(period_out), 32'd100);
        repeat (15 - LAT) tick();
        pwm = 1'b0;
        repeat (85) tick();

        // Stuck-high input times out in HIGH; the late fall is ignored.
        pulse_reset();
        repeat (5) tick();
        q.delete();
        pwm = 1'b1;
        rc  = cyc;
        wait_until(rc + T + 2);
        check("hi_timeout_before", 32'(timeout_out), 32'd0);
        tick();
        check("hi_timeout_at", 32'(timeout_out), 32'd1);
        pwm = 1'b0;
        repeat (20) tick();
        check("hi_fall_no_valid", 32'(q.size()), 32'd0);
        check("hi_timeout_sticky", 32'(timeout_out), 32'd1);
        run_frame(15, 100, rc);
        run_frame(15, 100, rc);
        repeat (LAT) tick();
        check("hi_recover_count", 32'(q.size()), 32'd1);
        if (q.size() == 1) begin
            check("hi_recover_high", q[0].h, 32'd15);
            check("hi_recover_period", q[0].p, 32'd100);
        end
        check("hi_recover_timeout", 32'(timeout_out), 32'd0);

        // Asynchronous reset between clock edges in the middle of a high phase.
        pwm = 1'b1;
        repeat (8) tick();
        check("ar_pre_high", 32'(high_out), 32'd15);
        #2;
        rst = 1'b1;
        #1;
        check("ar_high_cleared", 32'(high_out), 32'd0);
        check("ar_period_cleared", 32'(period_out), 32'd0);
        check("ar_valid_cleared", 32'(valid_out), 32'd0);
        check("ar_timeout_cleared", 32'(timeout_out), 32'd0);
        #2;
        rst = 1'b0;
        q.delete();
        repeat (5) tick();
        check("ar_first_rise_silent", 32'(q.size()), 32'd0);
        pwm = 1'b0;
        repeat (50) tick();
        run_frame(15, 100, rc);
        run_frame(15, 100, rc);
        repeat (LAT) tick();
        check("ar_valid_count", 32'(q.size()), 32'd2);
        if (q.size() == 2) begin
            check("ar_full_high", q[1].h, 32'd15);
            check("ar_full_period", q[1].p, 32'd100);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
